move_timer_sequencer: RTL
=========================

// Module: move_timer_sequencer
// PURPOSE
//  Timer-consuming end of the movement delay protocol. Accepts one target floor from the
//  priority queue, programs the delay timer per floor step and per door dwell, consumes the
//  timer's one-cycle pass pulse, and steps the car one floor per expiry. Sits between the
//  priority queue output and the delay timer in the movement subsystem.
// PARAMETERS
//  FLOOR_W      3     width of floor numbers
//  MAX_FLOOR    7     highest legal floor; floors 0..MAX_FLOOR
//  TRAVEL_DELAY 3'd5  timer delay code loaded per one-floor step
//  DOOR_DELAY   3'd7  timer delay code loaded for door dwell
//  START_FLOOR  0     current_floor value after reset
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        asynchronous reset, active-high
//  req_valid      in   1        target floor offered by priority queue
//  req_floor      in   FLOOR_W  target floor
//  req_ready      out  1        sequencer can accept a request (IDLE only)
//  timer_delay    out  3        delay code for the timer; stable while timer runs
//  timer_start    out  1        1-cycle pulse: restart timer count with timer_delay
//  timer_pass     in   1        1-cycle pulse: programmed delay expired
//  current_floor  out  FLOOR_W  floor the car is at
//  moving_up      out  1        car travelling upward (MOVE state)
//  moving_down    out  1        car travelling downward (MOVE state)
//  door_open      out  1        door dwell in progress
//  arrived        out  1        1-cycle pulse on reaching target
//  req_error      out  1        1-cycle pulse: request with req_floor > MAX_FLOOR dropped
// BEHAVIOUR
//  - All outputs registered. Reset (async, any time incl. mid-move): state IDLE,
//    current_floor=START_FLOOR, timer_delay=TRAVEL_DELAY, all 1-bit outputs 0 except req_ready=1.
//  - States IDLE, MOVE, DOOR. Handshake: transfer when req_valid && req_ready.
//  - IDLE: on transfer latch target. req_floor>MAX_FLOOR -> req_error pulse next cycle, stay IDLE.
//    target==current_floor -> DOOR, timer_delay=DOOR_DELAY, timer_start pulse, no arrived.
//    else -> MOVE, direction = (target>current_floor) ? up : down, timer_delay=TRAVEL_DELAY,
//    timer_start pulse. req_ready drops the cycle after transfer.
//  - MOVE: on timer_pass current_floor +/-1 (never wraps: clamps at 0 / MAX_FLOOR).
//    If new floor==target: arrived pulse, moving_* cleared, -> DOOR, DOOR_DELAY, timer_start.
//    Else stay MOVE, timer_start pulse again with TRAVEL_DELAY.
//  - DOOR: door_open=1; on timer_pass -> IDLE, door_open=0, req_ready=1 next cycle.
//  - timer_pass is ignored in IDLE and in any cycle where timer_start is high (stale expiry).
//  - timer_delay only changes together with a timer_start pulse.
//  - Latency: request accept -> timer_start 1 cycle; timer_pass -> floor update/timer_start 1 cycle.
//  - req_valid while busy: not accepted, queue holds it (req_ready=0); no buffering here.
//  - moving_up and moving_down never both 1; door_open never 1 while moving_*.
// TESTING
//  1 Reset: rst=1 mid-MOVE -> current_floor=0, req_ready=1, all pulses/flags 0 immediately.
//  2 Floor 0, req 3: timer_start x3 with delay 5, moving_up=1; after 3rd pass floor=3,
//    arrived 1 cycle, door_open=1, timer_delay=7; next pass -> req_ready=1.
//  3 Floor 3, req 1: moving_down, floor 3->2->1 on two passes, arrived once.
//  4 Request == current floor 2: no move, no arrived, DOOR with delay 7, back to IDLE on pass.
//  5 req_floor=7 with MAX_FLOOR=6: req_error pulse, stays IDLE, no timer_start.
//  6 Spurious timer_pass in IDLE and coincident with timer_start: no floor change, state held;
//    req_valid held during MOVE not accepted until IDLE.

Source files
------------

// File: rtl/move_timer_sequencer.sv
// Movement delay sequencer: takes one target floor, programs the delay timer per floor
// step and per door dwell, and steps the car one floor on each timer expiry.
module move_timer_sequencer #(
   parameter int         FLOOR_W      = 3,
   parameter int         MAX_FLOOR    = 7,
   parameter logic [2:0] TRAVEL_DELAY = 3'd5,
   parameter logic [2:0] DOOR_DELAY   = 3'd7,
   parameter int         START_FLOOR  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [FLOOR_W-1:0] req_floor,
   output logic               req_ready,
   output logic [2:0]         timer_delay,
   output logic               timer_start,
   input  logic               timer_pass,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               moving_up,
   output logic               moving_down,
   output logic               door_open,
   output logic               arrived,
   output logic               req_error
);

   localparam logic [FLOOR_W-1:0] MAX_F   = FLOOR_W'(MAX_FLOOR);
   localparam logic [FLOOR_W-1:0] START_F = FLOOR_W'(START_FLOOR);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t             state, state_n;
   logic [FLOOR_W-1:0] target, target_n;
   logic [FLOOR_W-1:0] current_floor_n, step_floor;
   logic [2:0]         timer_delay_n;
   logic               req_ready_n, timer_start_n, moving_up_n, moving_down_n;
   logic               door_open_n, arrived_n, req_error_n;
   logic               pass_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         target        <= START_F;
         current_floor <= START_F;
         timer_delay   <= TRAVEL_DELAY;
         req_ready     <= 1'b1;
         timer_start   <= 1'b0;
         moving_up     <= 1'b0;
         moving_down   <= 1'b0;
         door_open     <= 1'b0;
         arrived       <= 1'b0;
         req_error     <= 1'b0;
      end else begin
         state         <= state_n;
         target        <= target_n;
         current_floor <= current_floor_n;
         timer_delay   <= timer_delay_n;
         req_ready     <= req_ready_n;
         timer_start   <= timer_start_n;
         moving_up     <= moving_up_n;
         moving_down   <= moving_down_n;
         door_open     <= door_open_n;
         arrived       <= arrived_n;
         req_error     <= req_error_n;
      end
   end

   always_comb begin
      state_n         = state;
      target_n        = target;
      current_floor_n = current_floor;
      timer_delay_n   = timer_delay;
      req_ready_n     = req_ready;
      moving_up_n     = moving_up;
      moving_down_n   = moving_down;
      door_open_n     = door_open;
      timer_start_n   = 1'b0;
      arrived_n       = 1'b0;
      req_error_n     = 1'b0;

      // An expiry arriving alongside a fresh start belongs to the previous count.
      pass_ok = timer_pass && !timer_start;

      if (moving_up)
         step_floor = (current_floor == MAX_F) ? current_floor : current_floor + FLOOR_W'(1);
      else
         step_floor = (current_floor == '0) ? current_floor : current_floor - FLOOR_W'(1);

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (req_floor > MAX_F) begin
                  req_error_n = 1'b1;
               end else begin
                  target_n      = req_floor;
                  timer_start_n = 1'b1;
                  req_ready_n   = 1'b0;
                  if (req_floor == current_floor) begin
                     state_n       = DOOR;
                     door_open_n   = 1'b1;
                     timer_delay_n = DOOR_DELAY;
                  end else begin
                     state_n       = MOVE;
                     moving_up_n   = req_floor > current_floor;
                     moving_down_n = req_floor < current_floor;
                     timer_delay_n = TRAVEL_DELAY;
                  end
               end
            end
         end
         MOVE: begin
            if (pass_ok) begin
               current_floor_n = step_floor;
               timer_start_n   = 1'b1;
               if (step_floor == target) begin
                  state_n       = DOOR;
                  arrived_n     = 1'b1;
                  moving_up_n   = 1'b0;
                  moving_down_n = 1'b0;
                  door_open_n   = 1'b1;
                  timer_delay_n = DOOR_DELAY;
               end else begin
                  timer_delay_n = TRAVEL_DELAY;
               end
            end
         end
         DOOR: begin
            if (pass_ok) begin
               state_n     = IDLE;
               door_open_n = 1'b0;
               req_ready_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
